// File: rtl/avm_image_reader.sv
// Avalon-MM read master that fetches a run of consecutive ROM words, keeps them
// in a credit-managed return FIFO and presents them as a valid/ready stream.
module avm_image_reader #(
   parameter int ADDR_W     = 11,
   parameter int DATA_W     = 16,
   parameter int LEN_W      = 11,
   parameter int FIFO_DEPTH = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [LEN_W-1:0]  length,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   input  logic              avm_waitrequest,
   input  logic [DATA_W-1:0] avm_readdata,
   input  logic              avm_readdatavalid,
   output logic [DATA_W-1:0] st_data,
   output logic              st_valid,
   input  logic              st_ready,
   output logic              st_last
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_FINISH} state_t;

   state_t             state_q, state_d;
   logic [ADDR_W-1:0]  base_q, base_d;
   logic [LEN_W-1:0]   len_q, len_d;
   logic [LEN_W-1:0]   issued_q, issued_d;
   logic [LEN_W-1:0]   delivered_q, delivered_d;
   logic [CNT_W-1:0]   outstanding_q, outstanding_d;
   logic [CNT_W-1:0]   fifo_count_q, fifo_count_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0]  fifo_mem [FIFO_DEPTH];

   logic [CNT_W:0]     credit_used;
   logic               accept;
   logic               push;
   logic               pop;
   logic               last_word;

   // Every output is a function of registered state only, so no input ever
   // reaches an output combinationally; a stalled request therefore stays put.
   always_comb begin
      credit_used = (CNT_W+1)'(fifo_count_q) + (CNT_W+1)'(outstanding_q);
      avm_read    = (state_q == S_FETCH) && (issued_q < len_q) &&
                    (credit_used < (CNT_W+1)'(FIFO_DEPTH));
      avm_address = base_q + ADDR_W'(issued_q);
      accept      = avm_read && !avm_waitrequest;
      push        = avm_readdatavalid && (outstanding_q != '0);
      st_valid    = (fifo_count_q != '0);
      pop         = st_valid && st_ready;
      st_data     = st_valid ? fifo_mem[rd_ptr_q] : '0;
      last_word   = (delivered_q == len_q - LEN_W'(1));
      busy        = (state_q == S_FETCH) || (state_q == S_DRAIN);
      st_last     = st_valid && busy && last_word;
      done        = (state_q == S_FINISH);
   end

   // NOTE: every _d defaults to its _q first, so no path leaves a variable
   // unassigned and no latch can be inferred.
   always_comb begin
      state_d       = state_q;
      base_d        = base_q;
      len_d         = len_q;
      issued_d      = issued_q;
      delivered_d   = delivered_q;
      outstanding_d = outstanding_q;
      fifo_count_d  = fifo_count_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;

      if (accept) issued_d = issued_q + LEN_W'(1);
      if (pop) begin
         delivered_d = delivered_q + LEN_W'(1);
         rd_ptr_d    = rd_ptr_q + PTR_W'(1);
      end
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);

      case ({accept, push})
         2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
         2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
         default: outstanding_d = outstanding_q;
      endcase

      case ({push, pop})
         2'b10:   fifo_count_d = fifo_count_q + CNT_W'(1);
         2'b01:   fifo_count_d = fifo_count_q - CNT_W'(1);
         default: fifo_count_d = fifo_count_q;
      endcase

      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d      = base_addr;
               len_d       = length;
               issued_d    = '0;
               delivered_d = '0;
               state_d     = (length != '0) ? S_FETCH : S_FINISH;
            end
         end
         S_FETCH: begin
            if (accept && (issued_q + LEN_W'(1) == len_q)) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (pop && last_word) state_d = S_FINISH;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge value of every other flop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         base_q        <= '0;
         len_q         <= '0;
         issued_q      <= '0;
         delivered_q   <= '0;
         outstanding_q <= '0;
         fifo_count_q  <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
      end else begin
         state_q       <= state_d;
         base_q        <= base_d;
         len_q         <= len_d;
         issued_q      <= issued_d;
         delivered_q   <= delivered_d;
         outstanding_q <= outstanding_d;
         fifo_count_q  <= fifo_count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
      end
   end

   // NOTE: the storage array is not reset; emptiness is tracked by the reset
   // counters and st_data is masked to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) fifo_mem[wr_ptr_q] <= avm_readdata;
   end

endmodule
